// File: rtl/spi_slave_if.sv
// Bus bundle for the SPI responder: serial pins, tx handshake, rx output and status.
`timescale 1ns/1ps

interface spi_slave_if #(
  parameter int word_width = 8
);
  logic                  sck;
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [word_width-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [word_width-1:0] rx_data;
  logic                  rx_valid;
  logic                  underrun;
  logic                  busy;

  modport slave (
    input  sck, ss_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
  );

  modport master (
    output sck, ss_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI responder: oversamples sck/ss_n/mosi on clk and shifts words bit-serially.
// Define SPI_SLAVE_LSB_FIRST_EN to run both directions LSB first (default MSB first).
`timescale 1ns/1ps

module spi_slave #(
  parameter int word_width = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_slave_if.slave   bus
);

  localparam int cnt_w = $clog2(word_width);
  localparam logic [cnt_w-1:0] last_bit = cnt_w'(word_width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, next_state;
  logic [2:0]            sck_pipe, ss_pipe, mosi_pipe;
  logic [word_width-1:0] hold_reg, tx_shift, tx_next, rx_shift, rx_next, start_word;
  logic                  hold_full, pending, tx_bit;
  logic [cnt_w-1:0]      bit_cnt;
  logic                  lead, trail, sample_edge, shift_edge, ss_fall, ss_rise;
  logic                  word_start, word_done;

  // [0] and [1] form the synchroniser, [2] is the history bit for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_pipe  <= {3{CPOL}};
      ss_pipe   <= 3'b111;
      mosi_pipe <= 3'b000;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would collapse the pipeline.
      sck_pipe  <= {sck_pipe[1:0], bus.sck};
      ss_pipe   <= {ss_pipe[1:0], bus.ss_n};
      mosi_pipe <= {mosi_pipe[1:0], bus.mosi};
    end
  end

  assign lead        = (sck_pipe[2] == CPOL) && (sck_pipe[1] != CPOL);
  assign trail       = (sck_pipe[2] != CPOL) && (sck_pipe[1] == CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign ss_fall     = ss_pipe[2] & ~ss_pipe[1];
  assign ss_rise     = ~ss_pipe[2] & ss_pipe[1];
  assign start_word  = hold_full ? hold_reg : '0;

  // mosi is taken from its history bit: the value held just before the detected sck edge.
`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next = {mosi_pipe[2], rx_shift[word_width-1:1]};
  assign tx_bit  = tx_shift[0];
`else
  assign rx_next = {rx_shift[word_width-2:0], mosi_pipe[2]};
  assign tx_bit  = tx_shift[word_width-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    next_state = state;
    word_start = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          next_state = SHIFT;
          word_start = 1'b1;
        end
      end
      SHIFT: begin
        // A deselect coinciding with the last sample still delivers the word but starts no new one.
        if (sample_edge && bit_cnt == last_bit) begin
          word_done  = 1'b1;
          word_start = !ss_rise;
        end
        if (ss_rise) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      tx_shift  <= '0;
      tx_next   <= '0;
      pending   <= 1'b0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;

      // A handshake landing on a word start fills the register only after that word took its value.
      if (bus.tx_valid && !hold_full) begin
        hold_reg  <= bus.tx_data;
        hold_full <= 1'b1;
      end else if (word_start) begin
        hold_full <= 1'b0;
      end
      if (word_start && !hold_full) bus.underrun <= 1'b1;

      if (state == IDLE) begin
        if (word_start) begin
          bit_cnt  <= '0;
          rx_shift <= '0;
          if (CPHA) begin
            tx_shift <= '0;
            tx_next  <= start_word;
            pending  <= 1'b1;
          end else begin
            tx_shift <= start_word;
            pending  <= 1'b0;
          end
        end
      end else begin
        if (shift_edge) begin
          if (pending) begin
            tx_shift <= tx_next;
            pending  <= 1'b0;
          end else begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
            tx_shift <= {1'b0, tx_shift[word_width-1:1]};
`else
            tx_shift <= {tx_shift[word_width-2:0], 1'b0};
`endif
          end
        end
        if (sample_edge) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 1'b1;
          if (word_done) begin
            bus.rx_data  <= rx_next;
            bus.rx_valid <= 1'b1;
            bit_cnt      <= '0;
          end
          // Back-to-back word: staged now, driven out on the next shift edge.
          if (word_start) begin
            tx_next <= start_word;
            pending <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.miso     = (state == SHIFT) & tx_bit;
  assign bus.miso_oe  = (state == SHIFT);
  assign bus.busy     = (state == SHIFT);
  assign bus.tx_ready = ~hold_full;

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (target) for the existing SPI initiator block.
- SCK, MOSI and SS_n are oversampled on the system clock `clk` and shifted bit-serially.
- Received words go out on a valid pulse. Transmit words are accepted through a valid/ready handshake.
- Sits beside the IIC/SPI initiators so the design can loop back or act as a peripheral to an external master.

Parameters:
- word_width, 8, bits per SPI word; must be ≥2.
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = sample on the leading SCK edge; 1 = sample on the trailing SCK edge.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock from the master; asynchronous to clk.
- ss_n  in  1  slave select, active low; asynchronous.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  high while selected; external tristate enable.
- tx_data  in  word_width  next word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  tx holding register is empty.
- rx_data  out  word_width  last complete received word.
- rx_valid  out  1  one-clk pulse when rx_data updates.
- underrun  out  1  sticky; a word started with the tx holding register empty.
- busy  out  1  high in SHIFT.

Behaviour:
- Interface decisions: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, underrun=0, busy=0.
  - State is IDLE; shift registers and bit counter are cleared.
- Synchronisation:
  - sck, ss_n and mosi each pass through a 2-FF synchroniser, plus one history FF per signal for edge detection.
  - Legal SCK frequency is at most clk/4.
  - Input-to-internal-event latency is 3 clk.
- Edge definitions:
  - Leading edge = SCK transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1; the shift edge is the other one.
- Tx handshake:
  - Transfer occurs when tx_valid && tx_ready on a clk edge; the word goes into the holding register and tx_ready drops.
  - The holding register is consumed at each word start; tx_ready rises the following cycle.
  - If the register is empty at word start: shift 0s and set underrun. underrun is cleared only by reset.
- FSM:
  - IDLE: miso_oe=0 and miso=0. On synchronised ss_n falling: load the tx shift register (holding word or 0), bit counter=0, go to SHIFT.
  - SHIFT, common rules:
    - miso_oe=1; miso = current MSB of the tx shift register.
    - CPHA=0: the first bit is valid on miso immediately after entry.
    - CPHA=1: the first bit is presented on the first leading (shift) edge.
    - Every sample edge shifts synchronised mosi into the rx shift register LSB and increments the counter.
  - SHIFT, on shift edges:
    - CPHA=0: the tx register advances on each trailing edge.
    - CPHA=1: the first leading edge presents bit 0 only; each later leading edge advances.
  - SHIFT, word complete (word_width-th sample):
    - rx_data ← rx shift register and rx_valid pulses on the next clk.
    - Counter resets to 0 and the next word starts back-to-back (holding register consumed, underrun rules apply).
    - The next word's first bit is driven on the next shift edge.
  - SHIFT, ss_n rising (synchronised), any bit count:
    - Return to IDLE; the partial word is discarded with no rx_valid.
    - A rising ss_n on the same clk as the final sample edge still completes that word.
- Simultaneous events:
  - A tx handshake in the same cycle as word start: the new word is NOT used for this word; it waits in the holding register.
- Reset mid-transfer: immediate return to reset values; the master sees miso_oe=0.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined: both directions run LSB first.
  - miso drives tx shift register bit 0 and the register shifts right.
  - mosi enters at MSB (bit word_width-1) and shifts right.
- Undefined: MSB first as described in Behaviour. Ports and timing are identical either way.

Test Plan:
- Mode 0, word_width=8, tx handshake 8'hA5 before select; master sends 8'h3C at clk/8 → miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with one rx_valid pulse; tx_ready back to 1.
- Mode 3 (CPOL=1, CPHA=1); two back-to-back words with tx 8'h81 then 8'h7E loaded mid-first-word; master sends 8'hF0, 8'h0F → miso streams 81,7E; two rx_valid pulses carrying F0 then 0F.
- No tx word loaded, select and clock 8 bits of 8'h55 → miso all 0; underrun=1 and stays 1; rx_data=8'h55.
- ss_n released after 5 bits of 8'hFF → no rx_valid; rx_data keeps its previous value; busy=0 and miso_oe=0 within 3 clk.
- rst_n asserted mid-word (bit 3) → all outputs at reset values immediately; next full transfer of 8'h99 works correctly.
- SPI_SLAVE_LSB_FIRST_EN defined, tx 8'h01, master sends 8'h80 LSB first → miso first bit 1; rx_data=8'h80.
